// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU arbiter: FSM states, RV32 load/store funct3 codes, access size codes.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/lsu_arb_align_chk.sv
// Alignment checker: flags a misaligned access from the low address bits and the funct3 size field.
module lsu_arb_align_chk
    import lsu_arb_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] func3_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (func3_i[1:0])
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = addr_lo_i[0];
            SZ_W:    misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of the single LSU port: one access per grant, response two cycles after accept.
// Define LSU_ARB_RR_EN for round-robin arbitration; default is fixed priority with a port-1 starvation counter.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req_valid,
    output logic [1:0]  o_req_ready,
    input  logic [31:0] i_req_addr0,
    input  logic [31:0] i_req_addr1,
    input  logic        i_req_wren0,
    input  logic        i_req_wren1,
    input  logic [2:0]  i_req_func3_0,
    input  logic [2:0]  i_req_func3_1,
    input  logic [31:0] i_req_wdata0,
    input  logic [31:0] i_req_wdata1,
    output logic [1:0]  o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_lsu_addr,
    output logic        o_lsu_wren,
    output logic [2:0]  o_lsu_func3,
    output logic [31:0] o_lsu_st_data,
    input  logic [31:0] i_lsu_ld_data
);

    state_e      state_q;
    logic        id_q;
    logic [31:0] addr_q;
    logic        wren_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;
    logic [1:0]  resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misaligned;
    logic        arb_en;
    logic [1:0]  grant;

    assign arb_en = (state_q != ACCESS);

    lsu_arb_align_chk u_align_chk (
        .addr_lo_i    (addr_q[1:0]),
        .func3_i      (func3_q),
        .misaligned_o (misaligned)
    );

`ifdef LSU_ARB_RR_EN
    logic rr_ptr_q;

    // Pointer holds the last-granted port; on contention the other one wins.
    always_comb begin
        grant = '0;
        if (arb_en) begin
            if (i_req_valid == 2'b11) grant = rr_ptr_q ? 2'b01 : 2'b10;
            else                      grant = i_req_valid;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       rr_ptr_q <= 1'b0;
        else if (|grant) rr_ptr_q <= grant[1];
    end
`else
    logic [CNT_W-1:0] starve_q;
    logic             starved;

    assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        grant = '0;
        if (arb_en) begin
            if (i_req_valid[1] && (!i_req_valid[0] || starved)) grant = 2'b10;
            else if (i_req_valid[0])                             grant = 2'b01;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                        starve_q <= '0;
        else if (grant[1])                                starve_q <= '0;
        else if (arb_en && i_req_valid[1] && !starved)    starve_q <= starve_q + CNT_W'(1);
    end
`endif

    assign o_req_ready = grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            addr_q       <= '0;
            wren_q       <= 1'b0;
            func3_q      <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                IDLE, RESP: begin
                    if (|grant) begin
                        state_q <= ACCESS;
                        id_q    <= grant[1];
                        addr_q  <= grant[1] ? i_req_addr1   : i_req_addr0;
                        wren_q  <= grant[1] ? i_req_wren1   : i_req_wren0;
                        func3_q <= grant[1] ? i_req_func3_1 : i_req_func3_0;
                        wdata_q <= grant[1] ? i_req_wdata1  : i_req_wdata0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    resp_valid_q <= id_q ? 2'b10 : 2'b01;
                    rdata_q      <= (wren_q || misaligned) ? '0 : i_lsu_ld_data;
                    err_q        <= misaligned;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write strobe derives from the state register so reset kills it without waiting for a clock.
    assign o_lsu_wren    = (state_q == ACCESS) && wren_q && !misaligned;
    assign o_lsu_addr    = addr_q;
    assign o_lsu_func3   = func3_q;
    assign o_lsu_st_data = wdata_q;
    assign o_resp_valid  = resp_valid_q;
    assign o_resp_rdata  = rdata_q;
    assign o_resp_err    = err_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: random and directed requests against a rule-level reference model.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        wren0 = 1'b0, wren1 = 1'b0;
    logic [2:0]  f3_0 = '0, f3_1 = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic        lsu_wren;
    logic [2:0]  lsu_func3;

    typedef struct { logic [31:0] addr; logic wren; logic [2:0] f3; logic [31:0] wdata; } req_t;
    typedef struct { int cyc; logic [31:0] addr; logic [2:0] f3; logic [31:0] wdata; logic wren; } acc_t;
    typedef struct { int cyc; logic [1:0] vld; logic [31:0] rdata; logic err; } rsp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    acc_t accq[$];
    rsp_t rspq[$];
    logic [1:0] gnt_log[$];
    req_t slot[2];
    bit   pend[2];
    bit   granted[2];
    int   rate[2];
    bit   busy;
    int   cnt;
    bit   ptr;

    function automatic logic [31:0] ldv(input logic [31:0] a);
        logic [31:0] x;
        x = (a ^ 32'h5A5A0000) * 32'h01000193;
        return (a == 32'h2000) ? 32'hDEADBEEF : x;
    endfunction

    function automatic bit mis_f(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        sz = int'(f3 & 3'b011);
        if (sz == 3) return 1'b1;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    assign lsu_ld_data = ldv(lsu_addr);

    lsu_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr0   (addr0),
        .i_req_addr1   (addr1),
        .i_req_wren0   (wren0),
        .i_req_wren1   (wren1),
        .i_req_func3_0 (f3_0),
        .i_req_func3_1 (f3_1),
        .i_req_wdata0  (wdata0),
        .i_req_wdata1  (wdata1),
        .o_resp_valid  (resp_valid),
        .o_resp_rdata  (resp_rdata),
        .o_resp_err    (resp_err),
        .o_lsu_addr    (lsu_addr),
        .o_lsu_wren    (lsu_wren),
        .o_lsu_func3   (lsu_func3),
        .o_lsu_st_data (lsu_st_data),
        .i_lsu_ld_data (lsu_ld_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops expectations whose cycle has come, otherwise the LSU strobe and response must be idle.
    always @(negedge clk) begin
        if (!rst) begin
            while (accq.size() > 0 && accq[0].cyc < cyc) begin
                check("acc_missed", 32'(accq[0].cyc), 32'(cyc));
                void'(accq.pop_front());
            end
            if (accq.size() > 0 && accq[0].cyc == cyc) begin
                acc_t a;
                a = accq.pop_front();
                check("lsu_addr", lsu_addr, a.addr);
                check("lsu_func3", 32'(lsu_func3), 32'(a.f3));
                check("lsu_st_data", lsu_st_data, a.wdata);
                check("lsu_wren", 32'(lsu_wren), 32'(a.wren));
            end else begin
                check("lsu_wren_idle", 32'(lsu_wren), 32'd0);
            end
            while (rspq.size() > 0 && rspq[0].cyc < cyc) begin
                check("rsp_missed", 32'(rspq[0].cyc), 32'(cyc));
                void'(rspq.pop_front());
            end
            if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
                rsp_t r;
                r = rspq.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(r.vld));
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_err", 32'(resp_err), 32'(r.err));
            end else begin
                check("resp_valid_idle", 32'(resp_valid), 32'd0);
            end
        end
    end

    function automatic req_t rand_req();
        req_t r;
        r.addr  = 32'h1000 + 32'($urandom_range(0, 1023));
        r.wren  = 1'($urandom_range(0, 1));
        r.f3    = 3'($urandom_range(0, 7));
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (granted[p]) pend[p] = 1'b0;
            granted[p] = 1'b0;
            if (!pend[p] && rate[p] > 0 && int'($urandom_range(0, 99)) < rate[p]) begin
                slot[p] = rand_req();
                pend[p] = 1'b1;
            end
        end
        req_valid = {pend[1], pend[0]};
        addr0 = slot[0].addr;  wren0 = slot[0].wren;  f3_0 = slot[0].f3;  wdata0 = slot[0].wdata;
        addr1 = slot[1].addr;  wren1 = slot[1].wren;  f3_1 = slot[1].f3;  wdata1 = slot[1].wdata;
    endtask

    // Reference: an arbitration opportunity every cycle except the one right after a grant.
    task automatic model_step();
        int         win;
        logic [1:0] expr;
        acc_t       a;
        rsp_t       r;
        bit         m;
        win = -1;
        if (busy) begin
            busy = 1'b0;
        end else if (pend[0] || pend[1]) begin
`ifdef LSU_ARB_RR_EN
            if (pend[0] && pend[1]) win = ptr ? 0 : 1;
            else                    win = pend[1] ? 1 : 0;
            ptr = (win == 1);
`else
            win = (pend[1] && (!pend[0] || cnt == STARVE)) ? 1 : 0;
            if (win == 1)                      cnt = 0;
            else if (pend[1] && cnt < STARVE)  cnt = cnt + 1;
`endif
        end
        expr = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        check("req_ready", 32'(req_ready), 32'(expr));
        if (req_ready != 2'b00) gnt_log.push_back(req_ready);
        if (win >= 0) begin
            busy = 1'b1;
            granted[win] = 1'b1;
            m = mis_f(slot[win].addr, slot[win].f3);
            a.cyc = cyc + 1;  a.addr = slot[win].addr;  a.f3 = slot[win].f3;
            a.wdata = slot[win].wdata;  a.wren = slot[win].wren && !m;
            accq.push_back(a);
            r.cyc = cyc + 2;  r.vld = expr;  r.err = m;
            r.rdata = (slot[win].wren || m) ? 32'd0 : ldv(slot[win].addr);
            rspq.push_back(r);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            model_step();
        end
    endtask

    task automatic flush();
        accq.delete();
        rspq.delete();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            granted[p] = 1'b0;
            rate[p] = 0;
        end
        busy = 1'b0;
        cnt = 0;
        ptr = 1'b0;
        req_valid = '0;
    endtask

    task automatic do_reset(input bit check_vals);
        rst = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (check_vals) begin
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check("rst_resp_err", 32'(resp_err), 32'd0);
            check("rst_lsu_addr", lsu_addr, 32'd0);
            check("rst_lsu_wren", 32'(lsu_wren), 32'd0);
            check("rst_lsu_func3", 32'(lsu_func3), 32'd0);
            check("rst_lsu_st_data", lsu_st_data, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic w,
                         input logic [2:0] f3, input logic [31:0] d);
        slot[p].addr = a;  slot[p].wren = w;  slot[p].f3 = f3;  slot[p].wdata = d;
        pend[p] = 1'b1;
    endtask

    initial begin
        flush();
        do_reset(1'b1);

        // Directed: aligned word load, misaligned halfword store, aligned word store.
        issue(0, 32'h2000, 1'b0, F3_LW, 32'h0);
        run_cycles(4);
        issue(1, 32'h2003, 1'b1, F3_SH, 32'hFFFF_1234);
        run_cycles(4);
        issue(0, 32'h2004, 1'b1, F3_SW, 32'h12345678);
        run_cycles(4);

        // Reset while a store is in its LSU access cycle.
        issue(0, 32'h3000, 1'b1, F3_SW, 32'hCAFEF00D);
        run_cycles(1);
        @(posedge clk); #1;
        drive();
        check("wren_before_rst", 32'(lsu_wren), 32'd1);
        rst = 1'b1;
        #1;
        check("wren_during_rst", 32'(lsu_wren), 32'd0);
        check("resp_during_rst", 32'(resp_valid), 32'd0);
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        run_cycles(3);
        issue(1, 32'h2008, 1'b0, F3_LBU, 32'h0);
        run_cycles(4);

        // Both ports continuously requesting: fixed pattern of grants.
        do_reset(1'b0);
        gnt_log.delete();
        rate[0] = 100;
        rate[1] = 100;
        run_cycles(40);
        rate[0] = 0;
        rate[1] = 0;
        run_cycles(8);
        check("contention_grants", 32'(gnt_log.size() >= 18), 32'd1);
        for (int k = 0; k < 18 && k < gnt_log.size(); k++) begin
`ifdef LSU_ARB_RR_EN
            check("rr_pattern", 32'(gnt_log[k]), (k % 2 == 0) ? 32'd2 : 32'd1);
`else
            check("prio_pattern", 32'(gnt_log[k]), (k % 9 == 8) ? 32'd2 : 32'd1);
`endif
        end

        // Random traffic.
        do_reset(1'b0);
        rate[0] = 35;
        rate[1] = 35;
        run_cycles(2000);
        rate[0] = 0;
        rate[1] = 0;
        run_cycles(10);
        check("drain_acc", 32'(accq.size()), 32'd0);
        check("drain_rsp", 32'(rspq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
